dmem_port_master: RTL and testbench
===================================

# dmem_port_master

Initiator for the data-side (port B) of the dual-port instruction/data RAM. It accepts load/store requests from the core's memory stage over a valid/ready handshake and converts byte addresses and sizes into word addresses, byte strobes and lane-replicated write data. It captures the RAM's one-cycle read return, then shifts and sign/zero-extends it into a load result. It sits between the core's LSU stage and the RAM, one request in flight, with full-throughput back-to-back operation.

## Interface
- p_ADDR_BITS, 32, byte-address width; RAM word address width is the same.
- p_DATA_BITS, 32, data width; only 32 is supported.
- p_STRB_BITS, p_DATA_BITS/8, byte-strobe width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_addr  in  p_ADDR_BITS  byte address.
- req_wen  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata  in  p_DATA_BITS  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when resp_valid & resp_ready.
- resp_rdata  out  p_DATA_BITS  load result; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal-size request.
- addrb  out  p_ADDR_BITS  RAM word address = {2'b00, req_addr[p_ADDR_BITS-1:2]}.
- renb  out  1  RAM read enable.
- wenb  out  1  RAM write enable.
- webb  out  p_STRB_BITS  RAM byte strobes.
- datab  out  p_DATA_BITS  RAM write data.
- qb  in  p_DATA_BITS  RAM read data, valid the cycle after renb; holds until the next renb.

## Operation
- States: IDLE (resp_valid=0) and RESP (resp_valid=1). req_ready = !rst & (!resp_valid | resp_ready).
- Accept (fire) = req_valid & req_ready. On fire, register: byte offset addr[1:0], size, unsigned, wen, err. Next state is RESP.
- In RESP with resp_ready=1 and no fire, next state is IDLE. In RESP with fire, stay in RESP with new context.
- Error: size=3; size=1 & addr[0]; size=2 & addr[1:0]!=0. An error request still fires and responds with resp_err=1, resp_rdata=0. It never asserts renb or wenb.
- RAM drive is combinational from the request in the fire cycle. addrb is always driven from req_addr.
  - renb = fire & !req_wen & !err.
  - wenb = fire & req_wen & !err.
  - renb and wenb are never asserted together.
- Store strobes: byte → 4'b0001 << addr[1:0]; half → 4'b0011 << addr[1:0]; word → 4'b1111. webb is 0 when wenb=0.
- Store data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- Load result, computed combinationally from qb and the registered context:
  - Shift: sh = qb >> (8*offset).
  - byte → sh[7:0], extended per unsigned.
  - half → sh[15:0], extended per unsigned.
  - word → qb.
- Store response: resp_rdata=0, resp_err=0.
- resp_rdata stays stable while resp_valid & !resp_ready. This holds because qb only changes on renb, and renb requires fire.
- While rst=1: req_ready=0, renb=0, wenb=0, webb=0.

## Timing
- Request accepted in cycle T → response resp_valid=1 in T+1 for both loads and stores.
- Load data is valid combinationally in T+1.
- Back-to-back throughput is 1 request per cycle when resp_ready is held high.
- Backpressure: resp_ready=0 holds resp_valid, resp_rdata and resp_err, and holds req_ready=0.
- Reset values: resp_valid=0, resp_err=0, resp_rdata=0, all registered context 0, state IDLE.
- Reset during RESP drops the pending response. A store fired in the reset cycle is suppressed.

## Test plan
- Loads from RAM word 4 = 0x8081F2F3, one request per cycle:
  - LB @0x13 → 0xFFFFFF80.
  - LBU @0x13 → 0x00000080.
  - LH @0x12 → 0xFFFF8081.
  - LHU @0x10 → 0x0000F2F3.
  - LW @0x10 → 0x8081F2F3.
  - Check addrb=4 for every load and resp_valid held for 5 consecutive cycles.
- SB wdata=0x1234565A @0x11 → webb=4'b0010, datab=0x5A5A5A5A, resp_err=0. Following LW @0x10 → 0x80815AF3.
- SH wdata=0xBEEF @0x12 → webb=4'b1100, datab=0xBEEFBEEF. Following LW @0x10 → 0xBEEF5AF3.
- LW @0x12, SH @0x11, and size=3 @0x10 → each gives resp_err=1, resp_rdata=0, renb=wenb=0. Memory is unchanged.
- LW @0x10 with resp_ready=0 for 3 cycles → resp_rdata stable, req_ready=0, no renb. Raising resp_ready with a queued LB @0x13 → fire in the same cycle, next response 0xFFFFFFBE.
- rst asserted in the cycle after a load fires → resp_valid=0 in the following cycle. A store presented during rst → wenb=0, RAM unchanged.

Source files
------------

// File: rtl/dmem_port_master.sv
// -----------------------------------------------------------------------------
// dmem_port_master
//
// Data-side (port B) initiator for the dual-port instruction/data RAM. It
// accepts one load/store per cycle from the LSU stage, turns the byte address
// and size into a word address, byte strobes and lane-replicated write data,
// and turns the RAM's one-cycle read return into a shifted, sign- or
// zero-extended load result. At most one request is in flight.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready request handshake
//   req_addr        byte address
//   req_wen         1 = store, 0 = load
//   req_size        0 = byte, 1 = half, 2 = word, 3 = illegal
//   req_unsigned    loads: 1 = zero-extend, 0 = sign-extend
//   req_wdata       right-aligned store data
//   resp_valid/ready response handshake
//   resp_rdata      load result (0 for stores and errors)
//   resp_err        misaligned or illegal-size request
//   addrb, renb, wenb, webb, datab   RAM port B drive
//   qb              RAM port B read data (valid the cycle after renb)
// -----------------------------------------------------------------------------
module dmem_port_master #(
    parameter int p_ADDR_BITS = 32,
    parameter int p_DATA_BITS = 32,
    parameter int p_STRB_BITS = p_DATA_BITS / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [p_ADDR_BITS-1:0] req_addr,
    input  logic                   req_wen,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [p_DATA_BITS-1:0] req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [p_DATA_BITS-1:0] resp_rdata,
    output logic                   resp_err,
    output logic [p_ADDR_BITS-1:0] addrb,
    output logic                   renb,
    output logic                   wenb,
    output logic [p_STRB_BITS-1:0] webb,
    output logic [p_DATA_BITS-1:0] datab,
    input  logic [p_DATA_BITS-1:0] qb
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] off_q,   off_d;
    logic [1:0] size_q,  size_d;
    logic       uns_q,   uns_d;
    logic       wen_q,   wen_d;
    logic       err_q,   err_d;

    logic              fire_s;
    logic              err_s;
    logic [3:0]        strb_s;
    logic [p_DATA_BITS-1:0] sh_s;

    assign resp_valid = (state_q == ST_RESP);
    assign req_ready  = !rst && (!resp_valid || resp_ready);
    assign fire_s     = req_valid && req_ready;

    // Word address is the byte address with the lane bits dropped.
    assign addrb = {2'b00, req_addr[p_ADDR_BITS-1:2]};

    // Request legality: sizes must be naturally aligned, size 3 is illegal.
    always_comb begin
        err_s = 1'b0;
        case (req_size)
            2'd0:    err_s = 1'b0;
            2'd1:    err_s = req_addr[0];
            2'd2:    err_s = (req_addr[1:0] != 2'b00);
            default: err_s = 1'b1;
        endcase
    end

    // RAM port drive: enables, strobes and lane-replicated write data.
    always_comb begin
        renb   = 1'b0;
        wenb   = 1'b0;
        strb_s = 4'b0000;
        datab  = req_wdata;
        if (fire_s && !err_s) begin
            renb = !req_wen;
            wenb = req_wen;
        end else begin
            renb = 1'b0;
            wenb = 1'b0;
        end
        case (req_size)
            2'd0: begin
                strb_s = 4'b0001 << req_addr[1:0];
                datab  = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                strb_s = 4'b0011 << req_addr[1:0];
                datab  = {2{req_wdata[15:0]}};
            end
            2'd2: begin
                strb_s = 4'b1111;
                datab  = req_wdata;
            end
            default: begin
                strb_s = 4'b0000;
                datab  = req_wdata;
            end
        endcase
    end

    assign webb = wenb ? strb_s : 4'b0000;

    // Next-state and context capture; a fire always opens a new response.
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wen_d   = wen_q;
        err_d   = err_q;
        if (fire_s) begin
            state_d = ST_RESP;
            off_d   = req_addr[1:0];
            size_d  = req_size;
            uns_d   = req_unsigned;
            wen_d   = req_wen;
            err_d   = err_s;
        end else if (state_q == ST_RESP && resp_ready) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // State and request-context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wen_q   <= wen_d;
            err_q   <= err_d;
        end
    end

    // Load result: lane-shift the returned word, then extend. qb only moves
    // on renb, which needs a fire, so this stays stable under backpressure.
    assign sh_s = qb >> {off_q, 3'b000};

    // Response data and error, forced to zero outside a load response.
    always_comb begin
        resp_rdata = 32'h0000_0000;
        resp_err   = resp_valid && err_q;
        if (!resp_valid || wen_q || err_q) begin
            resp_rdata = 32'h0000_0000;
        end else begin
            case (size_q)
                2'd0:    resp_rdata = {{24{!uns_q && sh_s[7]}},  sh_s[7:0]};
                2'd1:    resp_rdata = {{16{!uns_q && sh_s[15]}}, sh_s[15:0]};
                default: resp_rdata = qb;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_master.sv
// -----------------------------------------------------------------------------
// Directed testbench for dmem_port_master with a small behavioural model of
// the RAM's port B (registered read on renb, byte-strobed write on wenb).
// -----------------------------------------------------------------------------
module tb_dmem_port_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] addrb;
    logic        renb;
    logic        wenb;
    logic [3:0]  webb;
    logic [31:0] datab;
    logic [31:0] qb;

    logic [31:0] mem [0:63];

    int tests;
    int fails;

    dmem_port_master dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wen      (req_wen),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .addrb        (addrb),
        .renb         (renb),
        .wenb         (wenb),
        .webb         (webb),
        .datab        (datab),
        .qb           (qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM port B model.
    always @(posedge clk) begin
        if (renb) qb <= mem[addrb[5:0]];
        if (wenb) begin
            for (int b = 0; b < 4; b++) begin
                if (webb[b]) mem[addrb[5:0]][8*b +: 8] <= datab[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic w,
                         input logic [1:0] s, input logic u, input logic [31:0] d);
        req_valid    = v;
        req_addr     = a;
        req_wen      = w;
        req_size     = s;
        req_unsigned = u;
        req_wdata    = d;
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        qb    = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'h8081_F2F3;
        rst = 1'b1;
        resp_ready = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 32'h0);

        // Reset state
        tick();
        tick();
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_req_ready",  {31'h0, req_ready},  32'h0);
        chk("rst_resp_err",   {31'h0, resp_err},   32'h0);
        chk("rst_resp_rdata", resp_rdata,          32'h0);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", {31'h0, req_ready}, 32'h1);

        // Back-to-back loads from word 4
        drive(1'b1, 32'h13, 1'b0, 2'd0, 1'b0, 32'h0);
        chk("lb_renb",  {31'h0, renb}, 32'h1);
        chk("lb_wenb",  {31'h0, wenb}, 32'h0);
        chk("lb_addrb", addrb, 32'h4);
        tick();
        chk("lb_valid", {31'h0, resp_valid}, 32'h1);
        chk("lb_rdata", resp_rdata, 32'hFFFF_FF80);
        drive(1'b1, 32'h13, 1'b0, 2'd0, 1'b1, 32'h0);
        chk("lbu_ready", {31'h0, req_ready}, 32'h1);
        chk("lbu_addrb", addrb, 32'h4);
        tick();
        chk("lbu_valid", {31'h0, resp_valid}, 32'h1);
        chk("lbu_rdata", resp_rdata, 32'h0000_0080);
        drive(1'b1, 32'h12, 1'b0, 2'd1, 1'b0, 32'h0);
        chk("lh_addrb", addrb, 32'h4);
        tick();
        chk("lh_valid", {31'h0, resp_valid}, 32'h1);
        chk("lh_rdata", resp_rdata, 32'hFFFF_8081);
        drive(1'b1, 32'h10, 1'b0, 2'd1, 1'b1, 32'h0);
        chk("lhu_addrb", addrb, 32'h4);
        tick();
        chk("lhu_valid", {31'h0, resp_valid}, 32'h1);
        chk("lhu_rdata", resp_rdata, 32'h0000_F2F3);
        drive(1'b1, 32'h10, 1'b0, 2'd2, 1'b0, 32'h0);
        chk("lw_addrb", addrb, 32'h4);
        tick();
        chk("lw_valid", {31'h0, resp_valid}, 32'h1);
        chk("lw_rdata", resp_rdata, 32'h8081_F2F3);
        chk("lw_err",   {31'h0, resp_err}, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 32'h0);
        tick();
        chk("drain_valid", {31'h0, resp_valid}, 32'h0);

        // Byte store then word readback
        drive(1'b1, 32'h11, 1'b1, 2'd0, 1'b0, 32'h1234_565A);
        chk("sb_wenb",  {31'h0, wenb}, 32'h1);
        chk("sb_renb",  {31'h0, renb}, 32'h0);
        chk("sb_webb",  {28'h0, webb}, 32'h2);
        chk("sb_datab", datab, 32'h5A5A_5A5A);
        tick();
        chk("sb_valid", {31'h0, resp_valid}, 32'h1);
        chk("sb_err",   {31'h0, resp_err}, 32'h0);
        chk("sb_rdata", resp_rdata, 32'h0);
        drive(1'b1, 32'h10, 1'b0, 2'd2, 1'b0, 32'h0);
        tick();
        chk("sb_lw_rdata", resp_rdata, 32'h8081_5AF3);

        // Half store then word readback
        drive(1'b1, 32'h12, 1'b1, 2'd1, 1'b0, 32'h0000_BEEF);
        chk("sh_wenb",  {31'h0, wenb}, 32'h1);
        chk("sh_webb",  {28'h0, webb}, 32'hC);
        chk("sh_datab", datab, 32'hBEEF_BEEF);
        tick();
        chk("sh_rdata", resp_rdata, 32'h0);
        drive(1'b1, 32'h10, 1'b0, 2'd2, 1'b0, 32'h0);
        tick();
        chk("sh_lw_rdata", resp_rdata, 32'hBEEF_5AF3);

        // Error requests
        drive(1'b1, 32'h12, 1'b0, 2'd2, 1'b0, 32'h0);
        chk("elw_renb", {31'h0, renb}, 32'h0);
        chk("elw_wenb", {31'h0, wenb}, 32'h0);
        tick();
        chk("elw_err",   {31'h0, resp_err}, 32'h1);
        chk("elw_rdata", resp_rdata, 32'h0);
        drive(1'b1, 32'h11, 1'b1, 2'd1, 1'b0, 32'h0000_1111);
        chk("esh_wenb", {31'h0, wenb}, 32'h0);
        chk("esh_webb", {28'h0, webb}, 32'h0);
        tick();
        chk("esh_err",   {31'h0, resp_err}, 32'h1);
        chk("esh_rdata", resp_rdata, 32'h0);
        drive(1'b1, 32'h10, 1'b1, 2'd3, 1'b0, 32'h2222_2222);
        chk("es3_wenb", {31'h0, wenb}, 32'h0);
        chk("es3_renb", {31'h0, renb}, 32'h0);
        tick();
        chk("es3_err",   {31'h0, resp_err}, 32'h1);
        chk("es3_rdata", resp_rdata, 32'h0);
        chk("err_mem",   mem[4], 32'hBEEF_5AF3);

        // Backpressure
        drive(1'b1, 32'h10, 1'b0, 2'd2, 1'b0, 32'h0);
        tick();
        chk("bp_rdata0", resp_rdata, 32'hBEEF_5AF3);
        chk("bp_err0",   {31'h0, resp_err}, 32'h0);
        resp_ready = 1'b0;
        drive(1'b1, 32'h13, 1'b0, 2'd0, 1'b0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
            chk("bp_renb",      {31'h0, renb}, 32'h0);
            tick();
            chk("bp_valid", {31'h0, resp_valid}, 32'h1);
            chk("bp_rdata", resp_rdata, 32'hBEEF_5AF3);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'h0, req_ready}, 32'h1);
        chk("bp_release_renb",  {31'h0, renb}, 32'h1);
        tick();
        chk("bp_lb_valid", {31'h0, resp_valid}, 32'h1);
        chk("bp_lb_rdata", resp_rdata, 32'hFFFF_FFBE);

        // Reset during a pending response, store suppressed under reset
        drive(1'b1, 32'h10, 1'b0, 2'd2, 1'b0, 32'h0);
        tick();
        chk("pre_rst_valid", {31'h0, resp_valid}, 32'h1);
        rst = 1'b1;
        drive(1'b1, 32'h10, 1'b1, 2'd0, 1'b0, 32'h0000_0077);
        chk("rst_st_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_st_wenb",  {31'h0, wenb}, 32'h0);
        chk("rst_st_renb",  {31'h0, renb}, 32'h0);
        chk("rst_st_webb",  {28'h0, webb}, 32'h0);
        tick();
        chk("rst_drop_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_drop_rdata", resp_rdata, 32'h0);
        rst = 1'b0;
        drive(1'b1, 32'h10, 1'b0, 2'd2, 1'b0, 32'h0);
        chk("post_rst_renb", {31'h0, renb}, 32'h1);
        tick();
        chk("post_rst_rdata", resp_rdata, 32'hBEEF_5AF3);
        chk("post_rst_mem",   mem[4], 32'hBEEF_5AF3);
        drive(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
